// File: rtl/iq_decimator.sv
// iq_decimator: 4-lane I/Q integrate-and-dump decimator; define IQ_DECIMATOR_SAT_EN for saturating output
module iq_decimator #(
    parameter int IN_W = 28,
    parameter int DEC_LOG2 = 4,
    parameter int SHIFT = 14,
    parameter int OUT_W = 24,
    localparam int ACC_W = IN_W + 2 + DEC_LOG2,
    localparam int BW = DEC_LOG2 > 0 ? DEC_LOG2 : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  inphase0_i,
    input  logic [IN_W-1:0]  inphase1_i,
    input  logic [IN_W-1:0]  inphase2_i,
    input  logic [IN_W-1:0]  inphase3_i,
    input  logic [IN_W-1:0]  quadrature0_i,
    input  logic [IN_W-1:0]  quadrature1_i,
    input  logic [IN_W-1:0]  quadrature2_i,
    input  logic [IN_W-1:0]  quadrature3_i,
    output logic [OUT_W-1:0] i_o,
    output logic [OUT_W-1:0] q_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic [BW-1:0]    beat_cnt_o
);
    localparam logic [BW-1:0] LAST = BW'((1 << DEC_LOG2) - 1);
    localparam logic signed [ACC_W:0] RND = ((ACC_W + 1)'(1) << SHIFT) >> 1;
`ifdef IQ_DECIMATOR_SAT_EN
    localparam logic signed [ACC_W:0] MAX_R = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_R = -MAX_R - 1;
`endif

    logic s1_valid_q, s1_valid_d, s2_dump_q, s2_dump_d, valid_q, valid_d, ovf_q, ovf_d;
    logic signed [IN_W+1:0] sum_i_q, sum_i_d, sum_q_q, sum_q_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic signed [ACC_W:0] r_i, r_q;
    logic [OUT_W:0] n_i, n_q;

    function automatic logic signed [IN_W+1:0] lane_sum(input logic [IN_W-1:0] a, b, c, d);
        return (IN_W + 2)'($signed(a)) + (IN_W + 2)'($signed(b))
             + (IN_W + 2)'($signed(c)) + (IN_W + 2)'($signed(d));
    endfunction

    // MSB of the result flags a clipped value
    function automatic logic [OUT_W:0] narrow(input logic signed [ACC_W:0] r);
`ifdef IQ_DECIMATOR_SAT_EN
        return r > MAX_R ? {1'b1, MAX_R[OUT_W-1:0]}
             : r < MIN_R ? {1'b1, MIN_R[OUT_W-1:0]}
             : {1'b0, r[OUT_W-1:0]};
`else
        return {1'b0, r[OUT_W-1:0]};
`endif
    endfunction

    always_comb begin
        s1_valid_d = valid_i;
        sum_i_d = valid_i ? lane_sum(inphase0_i, inphase1_i, inphase2_i, inphase3_i) : sum_i_q;
        sum_q_d = valid_i ? lane_sum(quadrature0_i, quadrature1_i, quadrature2_i, quadrature3_i) : sum_q_q;
        acc_i_d = !s1_valid_q ? acc_i_q
                : beat_cnt_q == '0 ? ACC_W'(sum_i_q) : acc_i_q + ACC_W'(sum_i_q);
        acc_q_d = !s1_valid_q ? acc_q_q
                : beat_cnt_q == '0 ? ACC_W'(sum_q_q) : acc_q_q + ACC_W'(sum_q_q);
        beat_cnt_d = !s1_valid_q ? beat_cnt_q : beat_cnt_q == LAST ? '0 : beat_cnt_q + 1'b1;
        s2_dump_d = s1_valid_q && beat_cnt_q == LAST;
        r_i = ((ACC_W + 1)'(acc_i_q) + RND) >>> SHIFT;
        r_q = ((ACC_W + 1)'(acc_q_q) + RND) >>> SHIFT;
        n_i = narrow(r_i);
        n_q = narrow(r_q);
        out_i_d = s2_dump_q ? n_i[OUT_W-1:0] : out_i_q;
        out_q_d = s2_dump_q ? n_q[OUT_W-1:0] : out_q_q;
        ovf_d = s2_dump_q ? n_i[OUT_W] | n_q[OUT_W] : ovf_q;
        valid_d = s2_dump_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_dump_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q <= 1'b0;
            sum_i_q <= '0;
            sum_q_q <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            beat_cnt_q <= '0;
            out_i_q <= '0;
            out_q_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_dump_q <= s2_dump_d;
            valid_q <= valid_d;
            ovf_q <= ovf_d;
            sum_i_q <= sum_i_d;
            sum_q_q <= sum_q_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            beat_cnt_q <= beat_cnt_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
        end
    end

    assign i_o = out_i_q;
    assign q_o = out_q_q;
    assign valid_o = valid_q;
    assign ovf_o = ovf_q;
    assign beat_cnt_o = beat_cnt_q;
endmodule

// File: tb/tb_iq_decimator.sv
// tb_iq_decimator: directed checks of iq_decimator at DEC_LOG2=2 (SHIFT 0 and 4) and DEC_LOG2=0
module tb_iq_decimator;
    localparam int W = 28;
    logic clk_i = 1'b0, rst_ni = 1'b0, valid_i = 1'b0;
    logic [W-1:0] li[4], lq[4];
    logic [23:0] ai, aq, bi, bq, ci, cq;
    logic av, bv, cv, ao, bo, co, cb;
    logic [1:0] ab, bb;
    int errors = 0, checks = 0;
    longint ei[12], eq[12];
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int cnt, prev;

    always #5 clk_i = ~clk_i;

    iq_decimator #(.IN_W(W), .DEC_LOG2(2), .SHIFT(0), .OUT_W(24)) dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .inphase0_i(li[0]), .inphase1_i(li[1]), .inphase2_i(li[2]), .inphase3_i(li[3]),
        .quadrature0_i(lq[0]), .quadrature1_i(lq[1]), .quadrature2_i(lq[2]), .quadrature3_i(lq[3]),
        .i_o(ai), .q_o(aq), .valid_o(av), .ovf_o(ao), .beat_cnt_o(ab));

    iq_decimator #(.IN_W(W), .DEC_LOG2(2), .SHIFT(4), .OUT_W(24)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .inphase0_i(li[0]), .inphase1_i(li[1]), .inphase2_i(li[2]), .inphase3_i(li[3]),
        .quadrature0_i(lq[0]), .quadrature1_i(lq[1]), .quadrature2_i(lq[2]), .quadrature3_i(lq[3]),
        .i_o(bi), .q_o(bq), .valid_o(bv), .ovf_o(bo), .beat_cnt_o(bb));

    iq_decimator #(.IN_W(W), .DEC_LOG2(0), .SHIFT(3), .OUT_W(24)) dut_c (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .inphase0_i(li[0]), .inphase1_i(li[1]), .inphase2_i(li[2]), .inphase3_i(li[3]),
        .quadrature0_i(lq[0]), .quadrature1_i(lq[1]), .quadrature2_i(lq[2]), .quadrature3_i(lq[3]),
        .i_o(ci), .q_o(cq), .valid_o(cv), .ovf_o(co), .beat_cnt_o(cb));

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input int i, input int q);
        for (int k = 0; k < 4; k++) begin
            li[k] = W'(i);
            lq[k] = W'(q);
        end
    endtask

    task automatic reset_dut;
        rst_ni = 1'b0;
        valid_i = 1'b0;
        tick;
        tick;
        chk("rst_valid", av, 0);
        chk("rst_i", $signed(ai), 0);
        chk("rst_q", $signed(aq), 0);
        chk("rst_ovf", ao, 0);
        chk("rst_beat", ab, 0);
        chk("rst_valid_b", bv, 0);
        rst_ni = 1'b1;
    endtask

    task automatic block4(input int ia, input int qa, input int ib, input int qb, input logic ov);
        valid_i = 1'b1;
        repeat (4) begin
            tick;
            chk("blk_quiet", av, 0);
        end
        valid_i = 1'b0;
        tick;
        chk("blk_quiet", av, 0);
        tick;
        chk("blk_valid_a", av, 1);
        chk("blk_valid_b", bv, 1);
        chk("blk_i_a", $signed(ai), ia);
        chk("blk_q_a", $signed(aq), qa);
        chk("blk_i_b", $signed(bi), ib);
        chk("blk_q_b", $signed(bq), qb);
        chk("blk_ovf_a", ao, ov);
        tick;
        chk("blk_strobe_end", av, 0);
        chk("blk_hold_i", $signed(ai), ia);
    endtask

    initial begin
        set_lanes(0, 0);
        reset_dut;

        set_lanes(1, -1);
        valid_i = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick;
            chk("cont_valid", av, (n >= 6 && n % 4 == 2) ? 1 : 0);
            chk("cont_beat", ab, (n - 1) % 4);
            if (n >= 6 && n % 4 == 2) begin
                chk("cont_i_a", $signed(ai), 16);
                chk("cont_q_a", $signed(aq), -16);
                chk("cont_i_b", $signed(bi), 1);
                chk("cont_q_b", $signed(bq), -1);
            end
        end

        reset_dut;
        li[0] = 28'd1; li[1] = 28'd1; li[2] = 28'd0; li[3] = 28'd0;
        lq[0] = -28'sd1; lq[1] = -28'sd1; lq[2] = 28'd0; lq[3] = 28'd0;
        block4(8, -8, 1, 0, 1'b0);

        reset_dut;
        li[0] = 28'd3; li[1] = 28'd0;
        lq[0] = -28'sd3; lq[1] = 28'd0;
        block4(12, -12, 1, -1, 1'b0);

        reset_dut;
        li[0] = 28'd1;
        lq[0] = -28'sd1;
        block4(4, -4, 0, 0, 1'b0);

        reset_dut;
        set_lanes(1, 1);
        cnt = 0;
        for (int n = 0; n < 7; n++) begin
            valid_i = pat[n][0];
            prev = cnt;
            cnt += pat[n];
            tick;
            chk("gap_beat", ab, prev % 4);
            chk("gap_quiet", av, 0);
        end
        valid_i = 1'b0;
        tick;
        chk("gap_quiet", av, 0);
        chk("gap_beat", ab, cnt % 4);
        tick;
        chk("gap_valid", av, 1);
        chk("gap_i", $signed(ai), 16);
        chk("gap_q", $signed(aq), 16);
        tick;
        chk("gap_strobe_end", av, 0);

        reset_dut;
        set_lanes(1, 1);
        valid_i = 1'b1;
        tick;
        tick;
        rst_ni = 1'b0;
        valid_i = 1'b0;
        tick;
        chk("mid_rst_valid", av, 0);
        tick;
        chk("mid_rst_valid", av, 0);
        chk("mid_rst_beat", ab, 0);
        rst_ni = 1'b1;
        set_lanes(2, 2);
        block4(32, 32, 2, 2, 1'b0);

        reset_dut;
        set_lanes((1 << 27) - 1, -(1 << 27));
`ifdef IQ_DECIMATOR_SAT_EN
        block4(8388607, -8388608, 8388607, -8388608, 1'b1);
`else
        block4(-16, 0, -1, 0, 1'b0);
`endif

        reset_dut;
        valid_i = 1'b1;
        for (int n = 0; n < 12; n++) begin
            longint si, sq;
            si = 0;
            sq = 0;
            for (int k = 0; k < 4; k++) begin
                int vi, vq;
                vi = int'($urandom_range(0, 1 << 20)) - (1 << 19);
                vq = int'($urandom_range(0, 1 << 20)) - (1 << 19);
                li[k] = W'(vi);
                lq[k] = W'(vq);
                si += vi;
                sq += vq;
            end
            ei[n] = (si + 4) >>> 3;
            eq[n] = (sq + 4) >>> 3;
            tick;
            if (n >= 2) begin
                chk("dec0_valid", cv, 1);
                chk("dec0_i", $signed(ci), ei[n-2]);
                chk("dec0_q", $signed(cq), eq[n-2]);
            end else begin
                chk("dec0_quiet", cv, 0);
            end
        end
        valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
